// File: rtl/fractcam_pkg.sv
// fractcam_pkg: shared sizing constants and the update-controller state type.
package fractcam_pkg;

    localparam int unsigned KEY_W      = 160;
    localparam int unsigned SLICE_W    = 5;
    localparam int unsigned NUM_SLICES = KEY_W / SLICE_W;
    localparam int unsigned BLK_SEL_W  = 7;
    localparam int unsigned SRL_DEPTH  = 32;
    localparam int unsigned CNT_W      = $clog2(SRL_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fractcam_slice_gen.sv
// fractcam_slice_gen: masked compare of the SRL address counter against one
// key slice; match_c is the bit to shift into that slice's SRL32.
// Ports: cnt (SRL address), key/mask (one slice), match_c (combinational result).
module fractcam_slice_gen #(
    parameter int unsigned SLICE_W = 5
) (
    input  logic [SLICE_W-1:0] cnt,
    input  logic [SLICE_W-1:0] key,
    input  logic [SLICE_W-1:0] mask,
    output logic               match_c
);

    // Address matches when every cared-for bit agrees with the key.
    always_comb begin
        match_c = (((cnt ^ key) & mask) == '0);
    end

endmodule

// File: rtl/fractcam_update_ctrl.sv
// fractcam_update_ctrl: serialises one ternary rule into the SRL32-based CAM
// by walking all 32 SRL addresses and shifting in a match bit per slice.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   upd_valid/upd_ready   - rule request handshake (ready only when idle)
//   upd_key/upd_mask      - rule value and care mask (1 = compare)
//   upd_blk               - target CAM block
//   upd_clear             - only with FRACTCAM_UPD_CLEAR_EN: write all zeros
//   wr, we_sel, srl_din   - SRL shift enable, block select, shift-in bits
//   search_stall          - CAM must not be searched while updating
//   upd_done              - one-cycle completion pulse
// Optional feature macro: FRACTCAM_UPD_CLEAR_EN.
module fractcam_update_ctrl #(
    parameter  int unsigned KEY_W      = fractcam_pkg::KEY_W,
    parameter  int unsigned SLICE_W    = fractcam_pkg::SLICE_W,
    parameter  int unsigned BLK_SEL_W  = fractcam_pkg::BLK_SEL_W,
    localparam int unsigned NUM_SLICES = KEY_W / SLICE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [KEY_W-1:0]      upd_key,
    input  logic [KEY_W-1:0]      upd_mask,
    input  logic [BLK_SEL_W-1:0]  upd_blk,
`ifdef FRACTCAM_UPD_CLEAR_EN
    input  logic                  upd_clear,
`endif
    output logic                  wr,
    output logic [BLK_SEL_W-1:0]  we_sel,
    output logic [NUM_SLICES-1:0] srl_din,
    output logic                  search_stall,
    output logic                  upd_done
);

    import fractcam_pkg::*;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [KEY_W-1:0]        key_q, key_d;
    logic [KEY_W-1:0]        mask_q, mask_d;
    logic [BLK_SEL_W-1:0]    blk_q, blk_d;
`ifdef FRACTCAM_UPD_CLEAR_EN
    logic                    clear_q, clear_d;
`endif
    logic                    wr_q, wr_d;
    logic [BLK_SEL_W-1:0]    we_sel_q, we_sel_d;
    logic [NUM_SLICES-1:0]   srl_din_q, srl_din_d;
    logic                    search_stall_q, search_stall_d;
    logic                    upd_ready_q, upd_ready_d;
    logic                    upd_done_q, upd_done_d;
    logic [NUM_SLICES-1:0]   match_c;

    // Outputs are registered from next-state values so they line up with the state.
    // The slice width equals the SRL address width, so cnt feeds each compare directly.
    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        fractcam_slice_gen #(.SLICE_W(SLICE_W)) u_slice (
            .cnt     (SLICE_W'(cnt_d)),
            .key     (key_d[i*SLICE_W +: SLICE_W]),
            .mask    (mask_d[i*SLICE_W +: SLICE_W]),
            .match_c (match_c[i])
        );
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        key_d          = key_q;
        mask_d         = mask_q;
        blk_d          = blk_q;
`ifdef FRACTCAM_UPD_CLEAR_EN
        clear_d        = clear_q;
`endif
        wr_d           = 1'b0;
        we_sel_d       = '0;
        srl_din_d      = '0;

        case (state_q)
            IDLE: begin
                if (upd_valid && upd_ready_q) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(SRL_DEPTH - 1);
                    key_d   = upd_key;
                    mask_d  = upd_mask;
                    blk_d   = upd_blk;
`ifdef FRACTCAM_UPD_CLEAR_EN
                    clear_d = upd_clear;
`endif
                end
            end
            SHIFT: begin
                // Stop after address 0 is written; never wrap.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        upd_ready_d    = (state_d == IDLE);
        search_stall_d = (state_d != IDLE);
        upd_done_d     = (state_d == DONE);
        if (state_d == SHIFT) begin
            wr_d      = 1'b1;
            we_sel_d  = blk_d;
            srl_din_d = match_c;
`ifdef FRACTCAM_UPD_CLEAR_EN
            if (clear_d) begin
                srl_din_d = '0;
            end
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            key_q          <= '0;
            mask_q         <= '0;
            blk_q          <= '0;
`ifdef FRACTCAM_UPD_CLEAR_EN
            clear_q        <= 1'b0;
`endif
            wr_q           <= 1'b0;
            we_sel_q       <= '0;
            srl_din_q      <= '0;
            search_stall_q <= 1'b0;
            upd_ready_q    <= 1'b1;
            upd_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key_q          <= key_d;
            mask_q         <= mask_d;
            blk_q          <= blk_d;
`ifdef FRACTCAM_UPD_CLEAR_EN
            clear_q        <= clear_d;
`endif
            wr_q           <= wr_d;
            we_sel_q       <= we_sel_d;
            srl_din_q      <= srl_din_d;
            search_stall_q <= search_stall_d;
            upd_ready_q    <= upd_ready_d;
            upd_done_q     <= upd_done_d;
        end
    end

    assign wr           = wr_q;
    assign we_sel       = we_sel_q;
    assign srl_din      = srl_din_q;
    assign search_stall = search_stall_q;
    assign upd_ready    = upd_ready_q;
    assign upd_done     = upd_done_q;

endmodule

// File: doc/fractcam_update_ctrl.md
FRACTCAM_UPDATE_CTRL -- requirements
Module: fractcam_update_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 160, meaning search-key width in bits.
REQ-002 SHALL have parameter SLICE_W, default 5, meaning key bits per SRL32 slice; NUM_SLICES = KEY_W/SLICE_W (32).
REQ-003 SHALL have parameter BLK_SEL_W, default 7, meaning width of the CAM block select.
REQ-004 SHALL clock all state on clk (input, 1), the single clock.
REQ-005 SHALL use reset (input, 1), synchronous, active-high.
REQ-006 SHALL have upd_valid (input, 1): a rule update is requested.
REQ-007 SHALL have upd_ready (output, 1): the block accepts a rule this cycle.
REQ-008 SHALL have upd_key (input, KEY_W): rule key value.
REQ-009 SHALL have upd_mask (input, KEY_W): care mask, where 1 = compare and 0 = don't-care.
REQ-010 SHALL have upd_blk (input, BLK_SEL_W): target CAM block.
REQ-011 SHALL have wr (output, 1): SRL shift enable to the CAM.
REQ-012 SHALL have we_sel (output, BLK_SEL_W): block select to the CAM.
REQ-013 SHALL have srl_din (output, NUM_SLICES): shift-in bit, one per slice.
REQ-014 SHALL have search_stall (output, 1): the CAM must not be searched.
REQ-015 SHALL have upd_done (output, 1): one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 SHALL drive upd_ready = 1 only in IDLE.
REQ-018 SHALL accept a rule on upd_valid && upd_ready, register key, mask and blk, load addr counter = 31, and go to SHIFT.
REQ-019 SHALL, in SHIFT, drive wr = 1 and we_sel = latched blk for exactly 32 cycles, with the counter decrementing 31→0.
REQ-020 SHALL, in SHIFT, drive srl_din[i] = ((cnt ^ key_slice_i) & mask_slice_i) == 0, with slice i = key bits [i*SLICE_W +: SLICE_W].
REQ-021 SHALL exit SHIFT when cnt == 0 (no wrap), so that after the final shift SRL address a holds the bit computed at cnt == a.
REQ-022 SHALL, in DONE, pulse upd_done = 1 for one cycle and return to IDLE; accept-to-upd_done latency = 33 cycles.
REQ-023 SHALL drive search_stall = 1 in SHIFT and DONE, and 0 in IDLE.
REQ-024 SHALL drive wr = 0, srl_din = 0 and we_sel = 0 outside SHIFT.
REQ-025 SHALL ignore upd_valid while busy; the requester holds upd_valid and its inputs until accepted.
REQ-026 SHALL treat upd_valid asserted in the DONE cycle as not accepted and accept it in the following IDLE cycle.
REQ-027 SHALL, with mask = 0, shift all ones (match-all rule).

Reset
REQ-028 SHALL, on reset, enter IDLE with cnt = 0, wr = 0, we_sel = 0, srl_din = 0, upd_done = 0, search_stall = 0 and upd_ready = 1 on the first cycle after release.
REQ-029 SHALL, on reset mid-SHIFT, abort immediately with no upd_done; the partially written SRL contents are undefined and the rule must be reissued.

Configuration
REQ-030 SHALL support macro FRACTCAM_UPD_CLEAR_EN: when defined, it adds input upd_clear (1), sampled at accept; a clear request runs the identical 32-cycle SHIFT with srl_din = 0, invalidating the block.
REQ-031 SHALL, when FRACTCAM_UPD_CLEAR_EN is undefined, have no upd_clear port; every accepted request is a rule write.

Structure
REQ-032 SHALL place KEY_W, SLICE_W, NUM_SLICES, BLK_SEL_W, SRL_DEPTH = 32 and the state enum in package fractcam_pkg.
REQ-033 SHALL instantiate sub-module fractcam_slice_gen NUM_SLICES times, each a combinational masked compare of cnt against one key/mask slice.

Verification
REQ-034 SHALL verify this scenario: key = 17, mask = all ones, blk = 0 → wr high 32 cycles, srl_din = 0 except at cnt = 17 on slice 0 (slices 1..31 match only at cnt = 0), upd_done at cycle 33.
REQ-035 SHALL verify this scenario: mask = 0, blk = 2 → srl_din = all ones for all 32 cycles, we_sel = 2 throughout SHIFT.
REQ-036 SHALL verify this scenario: key slice 0 = 5'b10100, mask slice 0 = 5'b11100 → slice 0 bit = 1 exactly for cnt = 20..23.
REQ-037 SHALL verify this scenario: back-to-back requests held valid → second accepted one cycle after upd_done, upd_ready low for 33 cycles per rule.
REQ-038 SHALL verify this scenario: reset asserted at SHIFT cycle 10 → next cycle wr = 0, no upd_done, upd_ready = 1 after release.
REQ-039 SHALL verify this scenario: with FRACTCAM_UPD_CLEAR_EN, upd_clear = 1 → 32 shifts of srl_din = 0, upd_done pulsed.
